// File: rtl/processor.sv
// Single-cycle Y86-64 core with a unified byte-addressed memory and a host download port.
module processor #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  mode,
    input  logic [63:0] uaddr,
    input  logic [63:0] idata,
    output logic [63:0] rax,
    output logic [63:0] rdx
);
    localparam logic [1:0]  RUN_MODE      = 2'h0;
    localparam logic [1:0]  RESET_MODE    = 2'h1;
    localparam logic [1:0]  DOWNLOAD_MODE = 2'h2;
    localparam logic [1:0]  UPLOAD_MODE   = 2'h3;
    localparam int          AW            = $clog2(MEM_BYTES);
    localparam logic [63:0] MEM_TOP       = 64'(MEM_BYTES);

    typedef enum logic [1:0] {STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS} stat_e;

    logic [7:0]    mem_q [MEM_BYTES];
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   regs_q [16];   // entry 15 is "no register" and always reads zero
    logic [63:0]   regs_d [16];
    logic [2:0]    cc_q, cc_d;    // {zf, sf, of}
    stat_e         stat_q, stat_d;

    logic [7:0]    ibyte [10];
    logic [3:0]    icode, ifun, ra, rb, ilen;
    logic [63:0]   val_a, val_b, rsp, val_c_jmp, val_c_mem, val_p, val_m, mem_addr, alu_out;
    logic          ins_ok, fetch_ok, data_ok, mem_rd, mem_wr, cnd, alu_of;
    logic          wr_en;
    logic [63:0]   wr_addr, wr_data;
    logic [AW-1:0] wb_addr [8];
    logic [7:0]    wb_en;

    assign rax = regs_q[0];
    assign rdx = regs_q[2];

    // Instruction fetch: ten bytes at PC, reading zero past the end of memory.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            ibyte[i] = 8'h00;
            if (pc_q + 64'(i) < MEM_TOP) ibyte[i] = mem_q[AW'(pc_q + 64'(i))];
        end
    end

    // Decode, condition evaluation, ALU and data-memory read.
    always_comb begin
        icode     = ibyte[0][7:4];
        ifun      = ibyte[0][3:0];
        ra        = ibyte[1][7:4];
        rb        = ibyte[1][3:0];
        val_a     = regs_q[ra];
        val_b     = regs_q[rb];
        rsp       = regs_q[4];
        val_c_jmp = {ibyte[8], ibyte[7], ibyte[6], ibyte[5], ibyte[4], ibyte[3], ibyte[2], ibyte[1]};
        val_c_mem = {ibyte[9], ibyte[8], ibyte[7], ibyte[6], ibyte[5], ibyte[4], ibyte[3], ibyte[2]};
        ilen      = 4'd1;
        ins_ok    = 1'b0;
        case (icode)
            4'h0, 4'h1, 4'h9: ins_ok = (ifun == 4'h0);
            4'h2: begin ilen = 4'd2;  ins_ok = (ifun <= 4'h6) && (ra != 4'hF) && (rb != 4'hF); end
            4'h3: begin ilen = 4'd10; ins_ok = (ifun == 4'h0) && (rb != 4'hF); end
            4'h4, 4'h5: begin ilen = 4'd10; ins_ok = (ifun == 4'h0) && (ra != 4'hF); end
            4'h6: begin ilen = 4'd2;  ins_ok = (ifun <= 4'h3) && (ra != 4'hF) && (rb != 4'hF); end
            4'h7: begin ilen = 4'd9;  ins_ok = (ifun <= 4'h6); end
            4'h8: begin ilen = 4'd9;  ins_ok = (ifun == 4'h0); end
            4'hA, 4'hB: begin ilen = 4'd2; ins_ok = (ifun == 4'h0) && (ra != 4'hF); end
            default: ;
        endcase
        val_p    = pc_q + 64'(ilen);
        fetch_ok = (pc_q < MEM_TOP) && (val_p <= MEM_TOP);

        cnd = 1'b0;
        case (ifun)
            4'h0: cnd = 1'b1;
            4'h1: cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2: cnd = cc_q[1] ^ cc_q[0];
            4'h3: cnd = cc_q[2];
            4'h4: cnd = ~cc_q[2];
            4'h5: cnd = ~(cc_q[1] ^ cc_q[0]);
            4'h6: cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
            default: ;
        endcase

        alu_of = 1'b0;
        case (ifun[1:0])
            2'd0: begin
                alu_out = val_b + val_a;
                alu_of  = (val_a[63] == val_b[63]) && (alu_out[63] != val_b[63]);
            end
            2'd1: begin
                alu_out = val_b - val_a;
                alu_of  = (val_a[63] != val_b[63]) && (alu_out[63] != val_b[63]);
            end
            2'd2:    alu_out = val_b & val_a;
            default: alu_out = val_b ^ val_a;
        endcase

        // Stack operations address below rsp for pushes, at rsp for pops.
        mem_addr = val_b + val_c_mem;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        case (icode)
            4'h4:       mem_wr = 1'b1;
            4'h5:       mem_rd = 1'b1;
            4'h8, 4'hA: begin mem_addr = rsp - 64'd8; mem_wr = 1'b1; end
            4'h9, 4'hB: begin mem_addr = rsp;         mem_rd = 1'b1; end
            default: ;
        endcase
        data_ok = !(mem_rd || mem_wr) || (mem_addr <= MEM_TOP - 64'd8);
        for (int i = 0; i < 8; i++) begin
            val_m[8*i +: 8] = 8'h00;
            if (mem_addr + 64'(i) < MEM_TOP) val_m[8*i +: 8] = mem_q[AW'(mem_addr + 64'(i))];
        end
    end

    // Next architectural state and the shared memory write port, per operating mode.
    always_comb begin
        pc_d    = pc_q;
        regs_d  = regs_q;
        cc_d    = cc_q;
        stat_d  = stat_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (mode[1:0])
            RUN_MODE: begin
                if (!mode[2] && stat_q == STAT_AOK) begin
                    if (!fetch_ok)          stat_d = STAT_ADR;
                    else if (!ins_ok)       stat_d = STAT_INS;
                    else if (icode == 4'h0) stat_d = STAT_HLT;
                    else if (!data_ok)      stat_d = STAT_ADR;
                    else begin
                        pc_d = val_p;
                        case (icode)
                            4'h2: if (cnd) regs_d[rb] = val_a;
                            4'h3: regs_d[rb] = val_c_mem;
                            4'h4: begin wr_en = 1'b1; wr_addr = mem_addr; wr_data = val_a; end
                            4'h5: regs_d[ra] = val_m;
                            4'h6: begin
                                regs_d[rb] = alu_out;
                                cc_d = {alu_out == 64'd0, alu_out[63], alu_of};
                            end
                            4'h7: if (cnd) pc_d = val_c_jmp;
                            4'h8: begin
                                wr_en = 1'b1; wr_addr = mem_addr; wr_data = val_p;
                                regs_d[4] = mem_addr;
                                pc_d = val_c_jmp;
                            end
                            4'h9: begin regs_d[4] = rsp + 64'd8; pc_d = val_m; end
                            4'hA: begin
                                wr_en = 1'b1; wr_addr = mem_addr; wr_data = val_a;
                                regs_d[4] = mem_addr;
                            end
                            // The loaded value is written last so pop %rsp keeps it.
                            4'hB: begin regs_d[4] = rsp + 64'd8; regs_d[ra] = val_m; end
                            default: ;
                        endcase
                    end
                end
            end
            DOWNLOAD_MODE: begin
                if (!mode[2]) begin
                    wr_en   = 1'b1;
                    wr_addr = uaddr;
                    wr_data = idata;
                end
            end
            UPLOAD_MODE: ;
            default: ;
        endcase
        if (mode[2] || mode[1:0] == RESET_MODE) begin
            pc_d   = '0;
            for (int i = 0; i < 16; i++) regs_d[i] = '0;
            cc_d   = 3'b100;
            stat_d = STAT_AOK;
        end
    end

    // Byte-lane split of the write port; lanes landing past the end are dropped.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            wb_addr[i] = AW'(wr_addr + 64'(i));
            wb_en[i]   = wr_en && (({1'b0, wr_addr} + 65'(i)) < 65'(MEM_BYTES));
        end
    end

    // Memory array: not cleared by any reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (wb_en[i]) mem_q[wb_addr[i]] <= wr_data[8*i +: 8];
        end
    end

    // Architectural state registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            cc_q   <= 3'b100;
            stat_q <= STAT_AOK;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            cc_q   <= cc_d;
            stat_q <= stat_d;
        end
    end
endmodule

// File: tb/tb_processor.sv
// Bench for processor: directed programs plus random programs checked against an ISA-level model.
module tb_processor;
    localparam int MEM = 1024;
    localparam logic [2:0] M_RUN = 3'd0, M_RST = 3'd1, M_DL = 3'd2, M_UP = 3'd3;
    localparam int S_AOK = 0, S_HLT = 1, S_ADR = 2, S_INS = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  mode;
    logic [63:0] uaddr, idata, rax, rdx;

    processor #(.MEM_BYTES(MEM)) dut (
        .clock(clock), .reset_n(reset_n), .mode(mode),
        .uaddr(uaddr), .idata(idata), .rax(rax), .rdx(rdx)
    );

    // Clock and reset
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_mem [MEM];
    logic [63:0] m_reg [16];
    logic [63:0] m_pc;
    logic        m_zf, m_sf, m_of;
    int          m_stat;
    int          len_tab [12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
    logic [7:0]  prog [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        m_stat = S_AOK;
    endtask

    function automatic logic [63:0] m_rd8(input logic [63:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = m_mem[int'(a) + i];
        return v;
    endfunction

    task automatic m_wr8(input logic [63:0] a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) m_mem[int'(a) + i] = v[8*i +: 8];
    endtask

    function automatic bit m_cond(input logic [3:0] f);
        bit lt;
        bit r;
        lt = m_sf ^ m_of;
        r = 1'b0;
        case (f)
            4'h0: r = 1'b1;
            4'h1: r = lt || m_zf;
            4'h2: r = lt;
            4'h3: r = m_zf;
            4'h4: r = !m_zf;
            4'h5: r = !lt;
            4'h6: r = !lt && !m_zf;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic bit m_legal(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] ra, input logic [3:0] rb);
        bit r;
        r = 1'b0;
        case (ic)
            4'h0, 4'h1, 4'h8, 4'h9: r = (f == 0);
            4'h2: r = (f <= 6) && (ra != 4'hF) && (rb != 4'hF);
            4'h3: r = (f == 0) && (rb != 4'hF);
            4'h4, 4'h5: r = (f == 0) && (ra != 4'hF);
            4'h6: r = (f <= 3) && (ra != 4'hF) && (rb != 4'hF);
            4'h7: r = (f <= 6);
            4'hA, 4'hB: r = (f == 0) && (ra != 4'hF);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic bit fits(input logic [63:0] a);
        return a <= 64'(MEM - 8);
    endfunction

    // One instruction of the ISA, applied to the model state.
    task automatic model_step();
        logic [3:0] ic, f, ra, rb;
        logic [7:0] b [10];
        logic [63:0] c_lo, c_hi, nxt, ea, v;
        logic signed [64:0] sa, sb, wide;
        int len;
        if (m_pc >= 64'(MEM)) begin m_stat = S_ADR; return; end
        ic = m_mem[int'(m_pc)][7:4];
        f  = m_mem[int'(m_pc)][3:0];
        len = (ic < 12) ? len_tab[ic] : 1;
        if (m_pc + 64'(len) > 64'(MEM)) begin m_stat = S_ADR; return; end
        for (int i = 0; i < 10; i++) b[i] = (m_pc + 64'(i) < 64'(MEM)) ? m_mem[int'(m_pc) + i] : 8'h00;
        ra = b[1][7:4];
        rb = b[1][3:0];
        c_lo = {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
        c_hi = {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]};
        if (!m_legal(ic, f, ra, rb)) begin m_stat = S_INS; return; end
        if (ic == 4'h0) begin m_stat = S_HLT; return; end
        nxt = m_pc + 64'(len);
        case (ic)
            4'h2: if (m_cond(f)) m_reg[rb] = m_reg[ra];
            4'h3: m_reg[rb] = c_hi;
            4'h4: begin
                ea = m_reg[rb] + c_hi;
                if (!fits(ea)) begin m_stat = S_ADR; return; end
                m_wr8(ea, m_reg[ra]);
            end
            4'h5: begin
                ea = m_reg[rb] + c_hi;
                if (!fits(ea)) begin m_stat = S_ADR; return; end
                m_reg[ra] = m_rd8(ea);
            end
            4'h6: begin
                sa = {m_reg[ra][63], m_reg[ra]};
                sb = {m_reg[rb][63], m_reg[rb]};
                case (f)
                    4'h0:    wide = sb + sa;
                    4'h1:    wide = sb - sa;
                    4'h2:    wide = {1'b0, m_reg[rb] & m_reg[ra]};
                    default: wide = {1'b0, m_reg[rb] ^ m_reg[ra]};
                endcase
                v = wide[63:0];
                m_of = (f < 2) ? (wide[64] != wide[63]) : 1'b0;
                m_zf = (v == 0);
                m_sf = v[63];
                m_reg[rb] = v;
            end
            4'h7: if (m_cond(f)) nxt = c_lo;
            4'h8: begin
                ea = m_reg[4] - 64'd8;
                if (!fits(ea)) begin m_stat = S_ADR; return; end
                m_wr8(ea, nxt);
                m_reg[4] = ea;
                nxt = c_lo;
            end
            4'h9: begin
                ea = m_reg[4];
                if (!fits(ea)) begin m_stat = S_ADR; return; end
                nxt = m_rd8(ea);
                m_reg[4] = ea + 64'd8;
            end
            4'hA: begin
                v = m_reg[ra];
                ea = m_reg[4] - 64'd8;
                if (!fits(ea)) begin m_stat = S_ADR; return; end
                m_wr8(ea, v);
                m_reg[4] = ea;
            end
            4'hB: begin
                ea = m_reg[4];
                if (!fits(ea)) begin m_stat = S_ADR; return; end
                v = m_rd8(ea);
                m_reg[4] = ea + 64'd8;
                m_reg[ra] = v;
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic model_edge(input logic [2:0] m, input logic [63:0] a, input logic [63:0] d);
        if (m[2] || m[1:0] == M_RST[1:0]) model_reset();
        else if (m[1:0] == M_DL[1:0]) begin
            for (int i = 0; i < 8; i++)
                if (a + 64'(i) < 64'(MEM)) m_mem[int'(a) + i] = d[8*i +: 8];
        end else if (m[1:0] == M_RUN[1:0] && m_stat == S_AOK) model_step();
    endtask

    // Driver tasks: inputs change 1 time unit after a rising edge, outputs are read there too.
    task automatic edge_cycle(input logic [2:0] m, input logic [63:0] a, input logic [63:0] d);
        mode = m; uaddr = a; idata = d;
        @(posedge clock);
        model_edge(m, a, d);
        #1;
    endtask

    task automatic run_check(input int n);
        for (int k = 0; k < n; k++) begin
            edge_cycle(M_RUN, '0, '0);
            check("run_rax", rax, m_reg[0]);
            check("run_rdx", rdx, m_reg[2]);
        end
    endtask

    task automatic load_prog();
        logic [63:0] w;
        while (prog.size() % 8 != 0) prog.push_back(8'h00);
        for (int k = 0; k < prog.size() / 8; k++) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = prog[8*k + i];
            edge_cycle(M_DL, 64'(8*k), w);
        end
        prog.delete();
        edge_cycle(M_RST, '0, '0);
    endtask

    task automatic a_q(input logic [63:0] v);
        for (int i = 0; i < 8; i++) prog.push_back(v[8*i +: 8]);
    endtask
    task automatic a_irmov(input logic [3:0] rb, input logic [63:0] v);
        prog.push_back(8'h30); prog.push_back({4'hF, rb}); a_q(v);
    endtask
    task automatic a_rr(input logic [7:0] op, input logic [3:0] ra, input logic [3:0] rb);
        prog.push_back(op); prog.push_back({ra, rb});
    endtask
    task automatic a_mem(input logic [7:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] d);
        prog.push_back(op); prog.push_back({ra, rb}); a_q(d);
    endtask
    task automatic a_jmp(input logic [7:0] op, input logic [63:0] dest);
        prog.push_back(op); a_q(dest);
    endtask

    function automatic logic [3:0] pick_reg();
        logic [3:0] r;
        case ($urandom_range(0, 3))
            0: r = 4'd0;
            1: r = 4'd2;
            2: r = 4'd3;
            default: r = 4'd6;
        endcase
        return r;
    endfunction

    initial begin
        int depth;
        logic [63:0] d;
        reset_n = 1'b0; mode = M_UP; uaddr = '0; idata = '0;
        model_reset();
        for (int i = 0; i < MEM; i++) m_mem[i] = 8'h00;
        #12;
        check("reset_rax", rax, 64'd0);
        check("reset_rdx", rdx, 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < MEM / 8; k++) edge_cycle(M_DL, 64'(8*k), 64'd0);

        // Sample program: irmovq $10,%rdx; irmovq $3,%rax; addq %rdx,%rax; halt
        edge_cycle(M_DL, 64'd0,  64'h00000000000af230);
        edge_cycle(M_DL, 64'd8,  64'h00000003f0300000);
        edge_cycle(M_DL, 64'd16, 64'h0000206000000000);
        edge_cycle(M_DL, 64'd24, 64'h0);
        edge_cycle(M_RST, '0, '0);
        run_check(1);
        check("t1_rdx_e1", rdx, 64'd10);
        run_check(1);
        check("t1_rax_e2", rax, 64'd3);
        run_check(1);
        check("t1_rax_e3", rax, 64'd13);
        check("t1_rdx_e3", rdx, 64'd10);
        run_check(5);
        check("t1_rax_hlt", rax, 64'd13);

        // Asynchronous reset in the middle of a run
        edge_cycle(M_RST, '0, '0);
        run_check(2);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("t2_async_rax", rax, 64'd0);
        check("t2_async_rdx", rdx, 64'd0);
        #1 reset_n = 1'b1;
        run_check(4);
        check("t2_rerun_rax", rax, 64'd13);

        // Taken je after subq leaves zero
        a_irmov(4'd0, 64'd5); a_irmov(4'd2, 64'd5); a_rr(8'h61, 4'd0, 4'd2);
        a_jmp(8'h73, 64'd41); a_irmov(4'd0, 64'd1); prog.push_back(8'h00);
        load_prog();
        run_check(8);
        check("t3_rax", rax, 64'd5);
        check("t3_rdx", rdx, 64'd0);

        // pushq / popq through the stack, then read the stack slot back
        a_irmov(4'd4, 64'h100); a_irmov(4'd0, 64'd7);
        a_rr(8'hA0, 4'd0, 4'hF); a_rr(8'hB0, 4'd2, 4'hF); prog.push_back(8'h00);
        load_prog();
        run_check(8);
        check("t4_rdx", rdx, 64'd7);
        a_mem(8'h50, 4'd0, 4'hF, 64'hF8); prog.push_back(8'h00);
        load_prog();
        run_check(3);
        check("t4_mem_f8", rax, 64'd7);

        // Illegal opcode freezes the core
        a_irmov(4'd0, 64'd9); prog.push_back(8'hF0); a_irmov(4'd0, 64'd1); prog.push_back(8'h00);
        load_prog();
        run_check(5);
        check("t5_ins_rax", rax, 64'd9);

        // Out-of-range data read freezes the core
        a_irmov(4'd2, 64'd4); a_mem(8'h50, 4'd2, 4'hF, 64'h1000);
        a_irmov(4'd2, 64'd1); prog.push_back(8'h00);
        load_prog();
        run_check(5);
        check("t5_adr_rdx", rdx, 64'd4);

        // UPLOAD and DOWNLOAD while halted leave registers alone; mode[2] clears
        edge_cycle(M_DL, 64'd0,  64'h00000000000af230);
        edge_cycle(M_DL, 64'd8,  64'h00000003f0300000);
        edge_cycle(M_DL, 64'd16, 64'h0000206000000000);
        edge_cycle(M_DL, 64'd24, 64'h0);
        edge_cycle(M_RST, '0, '0);
        run_check(6);
        for (int k = 0; k < 3; k++) edge_cycle(M_UP, 64'h40, 64'hdead);
        check("t6_up_rax", rax, 64'd13);
        check("t6_up_rdx", rdx, 64'd10);
        edge_cycle(M_DL, 64'h200, {$urandom, $urandom});
        edge_cycle(M_DL, 64'(MEM - 4), {$urandom, $urandom});
        check("t6_dl_rax", rax, 64'd13);
        check("t6_dl_rdx", rdx, 64'd10);
        edge_cycle(3'b110, '0, '0);
        check("t6_mode4_rax", rax, 64'd0);
        check("t6_mode4_rdx", rdx, m_reg[2]);

        // Random programs against the model
        for (int p = 0; p < 20; p++) begin
            depth = 0;
            a_irmov(4'd4, 64'h300);
            for (int n = 0; n < 12; n++) begin
                case ($urandom_range(0, 6))
                    0: a_irmov(pick_reg(), {$urandom, $urandom});
                    1: a_rr({4'h6, 4'($urandom_range(0, 3))}, pick_reg(), pick_reg());
                    2: a_rr({4'h2, 4'($urandom_range(0, 6))}, pick_reg(), pick_reg());
                    3: begin a_rr(8'hA0, pick_reg(), 4'hF); depth++; end
                    4: if (depth > 0) begin a_rr(8'hB0, pick_reg(), 4'hF); depth--; end
                       else prog.push_back(8'h10);
                    5: begin
                        d = 64'h380 + 64'(8 * $urandom_range(0, 3));
                        a_mem(8'h40, pick_reg(), 4'hF, d);
                        a_mem(8'h50, pick_reg(), 4'hF, d);
                    end
                    default: begin
                        a_jmp({4'h7, 4'($urandom_range(0, 6))}, 64'(prog.size() + 19));
                        a_irmov(pick_reg(), {$urandom, $urandom});
                    end
                endcase
            end
            prog.push_back(8'h00);
            load_prog();
            run_check(28);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
